// File: rtl/bitseq_looper_top_v2.sv
// Multi-channel looping bit-sequence generator with per-channel pattern RAM.
// Option macro BITSEQ_IDLE_HOLD_EN: io_out holds its last bit after a stop.
module bitseq_looper_top_v2 #(
    parameter  int NCH = 4,
    parameter  int AW  = 4,
    localparam int CHW = (NCH <= 1) ? 1 : $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        start_ch_bus,
    input  logic [NCH-1:0]        stop_ch_bus,
    input  logic                  sync_enable,
    input  logic [NCH-1:0]        arm_mask_in,
    input  logic                  arm_load,
    input  logic                  group_start,
    input  logic [NCH*(AW+1)-1:0] len_bus,
    input  logic [NCH*32-1:0]     rate_div_bus,
    input  logic [NCH*32-1:0]     phase_off_bus,
    input  logic                  wr_en,
    input  logic [CHW-1:0]        wr_ch,
    input  logic [AW-1:0]         wr_addr,
    input  logic                  wr_bit,
    output logic [NCH-1:0]        io_out,
    output logic [NCH-1:0]        playing
);

    localparam int DEP = 1 << AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [NCH-1:0] armed_q;
    logic [NCH-1:0] armed_d;
    logic [NCH-1:0] trig;

    // A group start consumes the old mask even when a new one loads alongside.
    always_comb begin
        armed_d = armed_q;
        if (arm_load) begin
            armed_d = arm_mask_in;
        end else if (group_start) begin
            armed_d = '0;
        end
    end

    assign trig = sync_enable ? (armed_q & {NCH{group_start}})
                              : start_ch_bus;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            armed_q <= '0;
        end else begin
            armed_q <= armed_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DEP-1:0] mem_q;
        logic [1:0]     st_q, st_d;
        logic [AW:0]    len_q, len_d;
        logic [AW:0]    len_in, len_eff;
        logic [31:0]    rate_q, rate_d;
        logic [31:0]    cnt_q, cnt_d;
        logic [31:0]    phase_in;
        logic [AW-1:0]  idx_q, idx_d, idx_nx;
        logic           io_q, io_d;
        logic           play_q, play_d;

        assign len_in   = len_bus[k*(AW+1) +: AW+1];
        assign len_eff  = (len_in > DEPTH) ? DEPTH : len_in;
        assign phase_in = phase_off_bus[k*32 +: 32];
        assign idx_nx   = ({1'b0, idx_q} == len_q - (AW+1)'(1))
                          ? '0 : idx_q + AW'(1);

        always_ff @(posedge clk) begin
            if (wr_en && !play_q && wr_ch == CHW'(k)) begin
                mem_q[wr_addr] <= wr_bit;
            end
        end

        always_comb begin
            st_d   = st_q;
            len_d  = len_q;
            rate_d = rate_q;
            cnt_d  = cnt_q;
            idx_d  = idx_q;
            io_d   = io_q;
            play_d = play_q;
            if (stop_ch_bus[k]) begin
                st_d   = S_IDLE;
                play_d = 1'b0;
`ifdef BITSEQ_IDLE_HOLD_EN
                io_d   = io_q;
`else
                io_d   = 1'b0;
`endif
            end else if (trig[k] && len_eff != '0) begin
                len_d  = len_eff;
                rate_d = rate_div_bus[k*32 +: 32];
                idx_d  = '0;
                play_d = 1'b1;
                if (phase_in == '0) begin
                    st_d  = S_RUN;
                    cnt_d = '0;
                    io_d  = mem_q[0];
                end else begin
                    st_d  = S_DELAY;
                    cnt_d = phase_in;
                    io_d  = 1'b0;
                end
            end else begin
                unique case (1'b1)
                    st_q == S_DELAY: begin
                        cnt_d = cnt_q - 32'd1;
                        if (cnt_q == 32'd1) begin
                            st_d = S_RUN;
                            io_d = mem_q[0];
                        end
                    end
                    st_q == S_RUN: begin
                        if (cnt_q == rate_q) begin
                            cnt_d = '0;
                            idx_d = idx_nx;
                            io_d  = mem_q[idx_nx];
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                st_q   <= S_IDLE;
                len_q  <= '0;
                rate_q <= '0;
                cnt_q  <= '0;
                idx_q  <= '0;
                io_q   <= 1'b0;
                play_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                len_q  <= len_d;
                rate_q <= rate_d;
                cnt_q  <= cnt_d;
                idx_q  <= idx_d;
                io_q   <= io_d;
                play_q <= play_d;
            end
        end

        assign io_out[k]  = io_q;
        assign playing[k] = play_q;
    end

endmodule

// File: tb/tb_bitseq_looper_top_v2.sv
// Randomized scoreboard bench for bitseq_looper_top_v2.
// Expected outputs come from a time-based model of each channel's playback.
module tb_bitseq_looper_top_v2;

    localparam int NCH = 4;
    localparam int AW  = 4;
    localparam int DEP = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NCH-1:0]        start_ch_bus = '0;
    logic [NCH-1:0]        stop_ch_bus = '0;
    logic                  sync_enable = 1'b0;
    logic [NCH-1:0]        arm_mask_in = '0;
    logic                  arm_load = 1'b0;
    logic                  group_start = 1'b0;
    logic [NCH*(AW+1)-1:0] len_bus = '0;
    logic [NCH*32-1:0]     rate_div_bus = '0;
    logic [NCH*32-1:0]     phase_off_bus = '0;
    logic                  wr_en = 1'b0;
    logic [1:0]            wr_ch = '0;
    logic [AW-1:0]         wr_addr = '0;
    logic                  wr_bit = 1'b0;
    logic [NCH-1:0]        io_out;
    logic [NCH-1:0]        playing;

    always #5 clk = ~clk;

    bitseq_looper_top_v2 #(.NCH(NCH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_ch_bus(start_ch_bus), .stop_ch_bus(stop_ch_bus),
        .sync_enable(sync_enable), .arm_mask_in(arm_mask_in),
        .arm_load(arm_load), .group_start(group_start),
        .len_bus(len_bus), .rate_div_bus(rate_div_bus),
        .phase_off_bus(phase_off_bus),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_bit(wr_bit),
        .io_out(io_out), .playing(playing)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2*NCH-1:0] exp_q[$];
    logic [2*NCH-1:0] mon_e;

    bit [DEP-1:0] m_mem [NCH];
    bit [DEP-1:0] m_pat [NCH];
    bit [NCH-1:0] m_play;
    bit [NCH-1:0] m_io;
    bit [NCH-1:0] m_armed;
    int           m_t0 [NCH];
    int           m_L  [NCH];
    longint       m_rate [NCH];
    longint       m_ph [NCH];

    // Bit index = elapsed time past the delay divided by the bit period.
    function automatic bit model_bit(int k, int c);
        longint el;
        longint j;
        el = longint'(c - m_t0[k]);
        if (el < m_ph[k]) return 1'b0;
        j = (el - m_ph[k]) / (m_rate[k] + 1);
        return m_pat[k][int'(j % longint'(m_L[k]))];
    endfunction

    task automatic model_reset();
        m_play  = '0;
        m_io    = '0;
        m_armed = '0;
    endtask

    task automatic tick();
        logic [2*NCH-1:0] e;
        bit [NCH-1:0] oldp;
        bit trg;
        int L;
        cyc++;
        if (rst_n) begin
            model_reset();
        end else begin
            oldp = m_play;
            for (int k = 0; k < NCH; k++) begin
                trg = sync_enable ? (group_start && m_armed[k])
                                  : start_ch_bus[k];
                L = int'(len_bus[k*5 +: 5]);
                if (L > DEP) L = DEP;
                if (stop_ch_bus[k]) begin
                    m_play[k] = 1'b0;
`ifndef BITSEQ_IDLE_HOLD_EN
                    m_io[k] = 1'b0;
`endif
                end else if (trg && L != 0) begin
                    m_play[k] = 1'b1;
                    m_t0[k]   = cyc;
                    m_L[k]    = L;
                    m_rate[k] = longint'(rate_div_bus[k*32 +: 32]);
                    m_ph[k]   = longint'(phase_off_bus[k*32 +: 32]);
                    m_pat[k]  = m_mem[k];
                end
                if (m_play[k]) m_io[k] = model_bit(k, cyc);
            end
            if (wr_en && int'(wr_ch) < NCH && !oldp[wr_ch])
                m_mem[wr_ch][wr_addr] = wr_bit;
            if (arm_load) m_armed = arm_mask_in;
            else if (group_start) m_armed = '0;
        end
        for (int k = 0; k < NCH; k++) begin
            e[k]       = m_io[k];
            e[NCH + k] = m_play[k];
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_ch_bus = '0;
        stop_ch_bus  = '0;
        arm_load     = 1'b0;
        group_start  = 1'b0;
        wr_en        = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic wr(int k, int a, bit b);
        wr_en   = 1'b1;
        wr_ch   = 2'(k);
        wr_addr = 4'(a);
        wr_bit  = b;
        tick();
    endtask

    task automatic wr_pat(int k, int n, logic [15:0] p);
        for (int i = 0; i < n; i++) wr(k, i, p[i]);
    endtask

    task automatic cfg(int k, int len, int rate, int ph);
        len_bus[k*5 +: 5]         = 5'(len);
        rate_div_bus[k*32 +: 32]  = 32'(rate);
        phase_off_bus[k*32 +: 32] = 32'(ph);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                total++;
                if ({playing, io_out} !== mon_e) begin
                    bad++;
                    $display("FAIL out t=%0t playing/io got %b/%b want %b/%b",
                             $time, playing, io_out,
                             mon_e[2*NCH-1:NCH], mon_e[NCH-1:0]);
                end
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        run(10);
        rst_n = 1'b0;
        for (int k = 0; k < NCH; k++)
            for (int a = 0; a < DEP; a++) wr(k, a, 1'b0);

        wr_pat(0, 10, 16'h5555);
        cfg(0, 10, 49, 0);
        start_ch_bus[0] = 1'b1;
        tick();
        run(520);

        wr_pat(1, 10, 16'hAAAA);
        cfg(1, 10, 9, 0);
        start_ch_bus[1] = 1'b1;
        tick();
        wr(0, 0, 1'b0);
        wr(0, 1, 1'b1);
        run(150);
        stop_ch_bus = 4'b0011;
        tick();
        run(5);

        wr_pat(0, 8, 16'h00AA);
        wr_pat(1, 8, 16'h0055);
        wr_pat(2, 8, 16'h00F0);
        wr_pat(3, 8, 16'h000F);
        for (int k = 0; k < NCH; k++) cfg(k, 8, 49, 0);
        sync_enable = 1'b1;
        arm_mask_in = 4'hF;
        arm_load    = 1'b1;
        tick();
        run(3);
        start_ch_bus = 4'hF;
        tick();
        group_start = 1'b1;
        tick();
        run(420);
        arm_mask_in = 4'b0011;
        arm_load    = 1'b1;
        tick();
        arm_mask_in = 4'b1100;
        arm_load    = 1'b1;
        group_start = 1'b1;
        tick();
        run(20);
        group_start = 1'b1;
        tick();
        run(20);
        stop_ch_bus = 4'hF;
        tick();
        sync_enable = 1'b0;

        wr_pat(2, 3, 16'h0003);
        cfg(2, 3, 0, 25);
        start_ch_bus[2] = 1'b1;
        tick();
        run(40);
        stop_ch_bus[2] = 1'b1;
        tick();

        cfg(3, 0, 0, 0);
        start_ch_bus[3] = 1'b1;
        tick();
        run(3);
        wr_pat(3, 16, 16'hC3A5);
        cfg(3, 31, 0, 0);
        start_ch_bus[3] = 1'b1;
        tick();
        run(40);
        cfg(3, 7, 1, 4);
        start_ch_bus[3] = 1'b1;
        tick();
        run(30);
        cfg(1, 5, 0, 0);
        start_ch_bus[1] = 1'b1;
        stop_ch_bus[1]  = 1'b1;
        tick();
        run(3);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) sync_enable = ~sync_enable;
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 19) == 0) start_ch_bus[k] = 1'b1;
                if ($urandom_range(0, 59) == 0) stop_ch_bus[k] = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                arm_load    = 1'b1;
                arm_mask_in = 4'($urandom);
            end
            if ($urandom_range(0, 29) == 0) group_start = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = 2'($urandom);
                wr_addr = 4'($urandom);
                wr_bit  = 1'($urandom);
            end
            if ($urandom_range(0, 9) == 0)
                cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
            tick();
        end

        sync_enable = 1'b0;
        for (int k = 0; k < NCH; k++) cfg(k, 9, 0, 0);
        start_ch_bus = 4'hF;
        tick();
        run(10);
        rst_n = 1'b1;
        #1;
        total++;
        if ({playing, io_out} !== '0) begin
            bad++;
            $display("FAIL async_reset got %b/%b want 0/0", playing, io_out);
        end
        model_reset();
        tick();
        rst_n = 1'b0;
        run(5);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitseq_looper_top_v2.md
Name: bitseq_looper_top_v2

Overview:
- Multi-channel looping bit-sequence generator.
- Each of NCH channels owns a 2^AW x 1-bit pattern RAM, written by a host through a simple write port.
- A started channel replays bits 0..len-1 cyclically on its own io_out pin, at its own bit rate, after its own start delay.
- Channels start individually, or together in sync mode through an arm-mask/group-start mechanism. Sits between the host register bank and the I/O pins.

Parameters:
- NCH, 4, number of channels (>=1).
- AW, 4, pattern address width; per-channel depth = 2^AW bits.
- CHW (derived, not overridable), 1 if NCH<=1 else clog2(NCH); width of wr_ch.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start_ch_bus  in  NCH  per-channel start pulse; honoured only when sync_enable=0.
- stop_ch_bus  in  NCH  per-channel stop pulse; honoured in both modes.
- sync_enable  in  1  1 = group-start mode, 0 = independent start.
- arm_mask_in  in  NCH  channels to arm for the next group start.
- arm_load  in  1  one-cycle strobe; latches arm_mask_in.
- group_start  in  1  one-cycle strobe; starts all armed channels on the same edge.
- len_bus  in  NCH*(AW+1)  packed lengths; channel k at [k*(AW+1) +: AW+1].
- rate_div_bus  in  NCH*32  packed bit-period divisors; channel k at [k*32 +: 32].
- phase_off_bus  in  NCH*32  packed start delays in clk cycles; channel k at [k*32 +: 32].
- wr_en  in  1  pattern write strobe.
- wr_ch  in  CHW  target channel.
- wr_addr  in  AW  bit address.
- wr_bit  in  1  bit value.
- io_out  out  NCH  registered serial outputs.
- playing  out  NCH  registered per-channel active flags.

Behaviour:
- Reset (rst_n=1, asynchronous): io_out=0, playing=0, arm mask=0, all channels IDLE, counters 0. Pattern RAM contents are not reset.
- Pattern write: on a clk edge with wr_en=1, mem[wr_ch][wr_addr] <= wr_bit.
  - Ignored if the target channel is playing, or if wr_ch >= NCH.
- Start trigger for channel k:
  - sync_enable=0: start_ch_bus[k]=1 at the edge.
  - sync_enable=1: group_start=1 at the edge and armed[k]=1. start_ch_bus is ignored in this mode.
- Arm mask:
  - arm_load=1 sets armed <= arm_mask_in.
  - group_start clears armed on the same edge, so one arm covers one group start.
  - If arm_load and group_start coincide, group_start uses the old mask; armed then <= arm_mask_in.
- On the trigger edge the channel latches len, rate_div and phase_off. Later bus changes do not affect a running channel until its next start.
- Effective length L = min(len, 2^AW). If L=0 the trigger is ignored.
- Per-channel state machine (IDLE, DELAY, RUN):
  - Trigger edge sets playing<=1. If phase_off=0: io_out<=mem[0], state RUN. Else: state DELAY, delay count=phase_off, io_out stays 0.
  - DELAY: count decrements each cycle; on the edge where it reaches 0, io_out<=mem[0] and state RUN. Bit 0 therefore appears exactly phase_off cycles after the trigger edge.
  - RUN: each bit is held for exactly rate_div+1 cycles. Then index advances; when index=L-1 it wraps to 0. rate_div=0 gives one bit per clk.
- Stop: stop_ch_bus[k]=1 at an edge gives IDLE, playing<=0, io_out<=0 on that edge. Stop wins over a simultaneous trigger.
- A trigger while already playing restarts the channel from bit 0 with newly latched config; the delay phase is re-applied.
- Channels are fully independent. Channels started by the same group_start edge stay bit-aligned when their configs are identical.

Optional Feature:
- Macro BITSEQ_IDLE_HOLD_EN.
- Defined: on stop, io_out holds the last driven bit instead of returning to 0. Reset still forces 0.
- Undefined: io_out=0 whenever the channel is not in RUN.

Test Plan:
- Reset: rst_n=1 for 10 cycles, then 0 -> io_out=0, playing=0; a write then read-back via playback succeeds.
- Single channel: ch0 pattern 1010101010, L=10, rate_div=49, phase=0, sync_enable=0, start ch0 -> playing[0]=1 next edge; io1 toggles every 50 cycles; the pattern repeats every 500 cycles; other channels stay 0.
- Second channel: while ch0 runs, write ch1 pattern 0101010101 and start ch1 -> io2 runs independently; writes to ch0 during play leave its pattern unchanged; stop ch0 and ch1 -> both io=0, playing=0 one edge later.
- Sync group: L=8, rate_div=49, patterns ch0 01010101, ch1 10101010, ch2 00001111, ch3 11110000; sync_enable=1, arm 4'b1111, arm_load, wait 3 cycles, group_start -> all playing bits rise on the same edge and bit boundaries are aligned across io1..io4; start_ch_bus pulses are ignored.
- Phase offset: ch2 phase_off=25, rate_div=0 -> bit 0 appears exactly 25 cycles after the trigger edge; with L=3 the pattern period is 3 cycles.
- Edge cases: len=0 start -> no play; len=31 with AW=4 -> wraps at 16; simultaneous start+stop -> stays idle; mid-run reset -> all outputs 0 immediately.
